// File: rtl/lcd_pio_pkg.sv
// Shared definitions for the LCD PIO sequencer: FSM states, PIO word
// field positions, the power-on init command ROM and the slow-command test.
package lcd_pio_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        IDLE,
        SETUP,
        ENH,
        HOLD,
        EXEC
    } state_t;

    localparam int TOG_BIT  = 31;
    localparam int RS_BIT   = 8;
    localparam int INIT_LEN = 5;

    // Issued in order [0]..[4]: function set x2, display on, clear, entry mode
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38};

    // Clear (0x01) and home (0x02/0x03) need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_pio_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// Holds at zero until reloaded.
module lcd_pio_timer
    import lcd_pio_pkg::*;
#(
    parameter int CW = 8,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] value,
    output logic          zero
);

    // Reload on request, otherwise count down and stick at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            value <= RST_VAL;
        else if (load)
            value <= load_val;
        else if (value != '0)
            value <= value - CW'(1);
    end

    assign zero = (value == '0);

endmodule

// File: rtl/lcd_pio_sequencer.sv
// Turns toggle-flagged PIO words into timed HD44780 write cycles.
// Optional autonomous power-on init: define LCD_PIO_SEQ_INIT_EN.
module lcd_pio_sequencer
    import lcd_pio_pkg::*;
#(
    parameter int T_SETUP     = 4,
    parameter int T_EN        = 25,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int T_PWRUP     = 800000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_word,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        busy
);

    localparam int MAXV = (T_PWRUP > T_EXEC_LONG) ? T_PWRUP : T_EXEC_LONG;
    localparam int CW   = $clog2(MAXV + 1);

`ifdef LCD_PIO_SEQ_INIT_EN
    localparam state_t          RST_STATE = INIT_WAIT;
    localparam logic            RST_BUSY  = 1'b1;
    localparam logic [CW-1:0]   TMR_RST   = CW'(T_PWRUP - 1);
`else
    localparam state_t          RST_STATE = IDLE;
    localparam logic            RST_BUSY  = 1'b0;
    localparam logic [CW-1:0]   TMR_RST   = '0;
`endif

    state_t        state;
    logic          last_tog;
    logic          pending;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_value_unused;
    logic          tmr_zero;
    logic          init_more;
    logic          unused_bits;

    assign pending     = cmd_word[TOG_BIT] ^ last_tog;
    assign lcd_rw      = 1'b0;
    assign unused_bits = ^cmd_word[TOG_BIT-1:RS_BIT+1];

`ifdef LCD_PIO_SEQ_INIT_EN
    logic       init_run;
    logic [2:0] init_idx;
    logic [2:0] next_idx;
    assign next_idx  = init_idx + 3'd1;
    assign init_more = init_run && (init_idx != 3'(INIT_LEN - 1));
`else
    assign init_more = 1'b0;
`endif

    lcd_pio_timer #(
        .CW      (CW),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value_unused),
        .zero     (tmr_zero)
    );

    // Counter reload on every state entry, with that state's length minus one
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            INIT_WAIT: if (tmr_zero) begin tmr_load = 1'b1; tmr_val = CW'(T_SETUP - 1); end
            IDLE:      if (pending)  begin tmr_load = 1'b1; tmr_val = CW'(T_SETUP - 1); end
            SETUP:     if (tmr_zero) begin tmr_load = 1'b1; tmr_val = CW'(T_EN - 1);    end
            ENH:       if (tmr_zero) begin tmr_load = 1'b1; tmr_val = CW'(T_HOLD - 1);  end
            HOLD: if (tmr_zero) begin
                tmr_load = 1'b1;
                tmr_val  = is_long_cmd(lcd_rs, lcd_data) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
            end
            EXEC:      if (tmr_zero && init_more) begin tmr_load = 1'b1; tmr_val = CW'(T_SETUP - 1); end
            default: ;
        endcase
    end

    // Transaction FSM; all pin outputs are registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RST_STATE;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_on   <= 1'b0;
            busy     <= RST_BUSY;
            last_tog <= 1'b0;
`ifdef LCD_PIO_SEQ_INIT_EN
            init_run <= 1'b1;
            init_idx <= 3'd0;
`endif
        end else begin
            lcd_on <= 1'b1;
            case (state)
`ifdef LCD_PIO_SEQ_INIT_EN
                INIT_WAIT: if (tmr_zero) begin
                    lcd_data <= INIT_ROM[0];
                    lcd_rs   <= 1'b0;
                    state    <= SETUP;
                end
`endif
                IDLE: if (pending) begin
                    lcd_data <= cmd_word[7:0];
                    lcd_rs   <= cmd_word[RS_BIT];
                    last_tog <= cmd_word[TOG_BIT];
                    busy     <= 1'b1;
                    state    <= SETUP;
                end
                SETUP: if (tmr_zero) begin
                    lcd_en <= 1'b1;
                    state  <= ENH;
                end
                ENH: if (tmr_zero) begin
                    lcd_en <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: if (tmr_zero) state <= EXEC;
                EXEC: if (tmr_zero) begin
                    if (init_more) begin
`ifdef LCD_PIO_SEQ_INIT_EN
                        init_idx <= next_idx;
                        lcd_data <= INIT_ROM[next_idx];
                        lcd_rs   <= 1'b0;
`endif
                        state <= SETUP;
                    end else begin
`ifdef LCD_PIO_SEQ_INIT_EN
                        init_run <= 1'b0;
`endif
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_pio_sequencer.sv
// Self-checking bench for lcd_pio_sequencer: a transaction-timeline model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_lcd_pio_sequencer;

    localparam int TS = 4, TE = 25, TH = 4, TX = 40, TXL = 200, TP = 300;
`ifdef LCD_PIO_SEQ_INIT_EN
    localparam logic EXP_RST_BUSY = 1'b1;
`else
    localparam logic EXP_RST_BUSY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cmd_word = 32'h0;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy;

    always #5 clk = ~clk;

    lcd_pio_sequencer #(
        .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
        .T_EXEC(TX), .T_EXEC_LONG(TXL), .T_PWRUP(TP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_word(cmd_word),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .lcd_on(lcd_on), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model: one transaction timeline ----------------
    int         n = 0;
    bit         active = 0, init_wait = 0;
    int         t_acc = 0, dur = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_rs = 1'b0, m_tog = 1'b0, m_on = 1'b0;
    logic [7:0] init_q[$];

    function automatic int exec_len(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? TXL : TX;
    endfunction

    task automatic start(input logic [7:0] d, input logic rs);
        active = 1;
        t_acc  = n;
        m_data = d;
        m_rs   = rs;
        dur    = TS + TE + TH + exec_len(rs, d);
    endtask

    task automatic model_reset();
        n = 0; active = 0; m_data = 8'h00; m_rs = 1'b0; m_tog = 1'b0; m_on = 1'b0;
`ifdef LCD_PIO_SEQ_INIT_EN
        init_wait = 1;
        init_q = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
`else
        init_wait = 0;
        init_q = {};
`endif
    endtask

    // Advance the model once per clock edge
    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else begin
            n++;
            m_on = 1'b1;
            if (init_wait) begin
                if (n == TP) begin
                    init_wait = 0;
                    start(init_q.pop_front(), 1'b0);
                end
            end else if (active) begin
                if (n == t_acc + dur) begin
                    active = 0;
                    if (init_q.size() > 0) start(init_q.pop_front(), 1'b0);
                end
            end else if (cmd_word[31] != m_tog) begin
                m_tog = cmd_word[31];
                start(cmd_word[7:0], cmd_word[8]);
            end
        end
    end

    // Per-cycle compare of all pins against the model
    always @(negedge clk) begin
        if (reset_n) begin
            logic exp_en, exp_busy;
            exp_en   = active && (n - t_acc) >= TS && (n - t_acc) < TS + TE;
            exp_busy = active || init_wait;
            chk("cycle{data,rs,rw,en,on,busy}",
                {19'd0, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy},
                {19'd0, m_data, m_rs, 1'b0, exp_en, m_on, exp_busy});
        end
    end

    // ---------------- measurement monitor ----------------
    int cyc = 0, busy_rises = 0, busy_cnt = 0, last_busy_len = 0, busy_rise_cyc = 0;
    int en_pulses = 0, en_cnt = 0, last_en_len = 0, en_rise_cyc = 0;
    logic prev_busy = 1'b0, prev_en = 1'b0;
    logic [7:0] en_data[$];

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_busy = EXP_RST_BUSY;
            prev_en   = 1'b0;
        end else begin
            if (busy && !prev_busy) begin busy_rises++; busy_rise_cyc = cyc; busy_cnt = 0; end
            if (busy) busy_cnt++;
            if (!busy && prev_busy) last_busy_len = busy_cnt;
            if (lcd_en && !prev_en) begin en_pulses++; en_rise_cyc = cyc; en_cnt = 0; en_data.push_back(lcd_data); end
            if (lcd_en) en_cnt++;
            if (!lcd_en && prev_en) last_en_len = en_cnt;
            prev_busy = busy;
            prev_en   = lcd_en;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic v, input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            tick(1);
            if (busy === v) return;
        end
        checks++; failures++;
        $display("FAIL %s timeout busy=%0b required=%0b", nm, busy, v);
    endtask

    task automatic wait_en(input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            tick(1);
            if (lcd_en === 1'b1) return;
        end
        checks++; failures++;
        $display("FAIL %s timeout en=%0b required=1", nm, lcd_en);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_data"}, {24'd0, lcd_data}, 32'h0);
        chk({nm, "_rs"},   {31'd0, lcd_rs},   32'h0);
        chk({nm, "_rw"},   {31'd0, lcd_rw},   32'h0);
        chk({nm, "_en"},   {31'd0, lcd_en},   32'h0);
        chk({nm, "_on"},   {31'd0, lcd_on},   32'h0);
        chk({nm, "_busy"}, {31'd0, busy},     {31'd0, EXP_RST_BUSY});
    endtask

    int p0, r0;

    initial begin
        tick(3);
        chk_reset_vals("rst");
        @(negedge clk);
        reset_n = 1'b1;

`ifdef LCD_PIO_SEQ_INIT_EN
        // PIO request during init is served right after the init sequence
        tick(10);
        cmd_word = 32'h8000_0141;
        for (int i = 0; i < 3000 && en_pulses < 6; i++) tick(1);
        chk("init_pulses", en_pulses, 6);
        begin
            logic [7:0] exp_seq [6] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06, 8'h41};
            for (int i = 0; i < 6; i++)
                if (en_data.size() > i) chk($sformatf("init_seq%0d", i), {24'd0, en_data[i]}, {24'd0, exp_seq[i]});
        end
        wait_busy(1'b0, 200, "init_A_done");
`else
        // 'A' data write: timing pinned with literals
        tick(3);
        cmd_word = 32'h8000_0141;
        wait_busy(1'b1, 5, "A_accept");
        chk("A_data", {24'd0, lcd_data}, 32'h41);
        chk("A_rs", {31'd0, lcd_rs}, 32'h1);
        wait_busy(1'b0, 200, "A_done");
        chk("A_busy_len", last_busy_len, 73);
        chk("A_en_len", last_en_len, 25);
        chk("A_en_offset", en_rise_cyc - busy_rise_cyc, 4);
        chk("A_pulses", en_pulses, 1);
`endif

        // Clear: long execution wait
        tick(3);
        p0 = en_pulses;
        cmd_word = 32'h0000_0001;
        wait_busy(1'b1, 5, "clr_accept");
        chk("clr_rs", {31'd0, lcd_rs}, 32'h0);
        wait_busy(1'b0, 400, "clr_done");
        chk("clr_busy_len", last_busy_len, 233);
        chk("clr_pulses", en_pulses, p0 + 1);

        // Toggle unchanged: nothing happens
        tick(2);
        r0 = busy_rises; p0 = en_pulses;
        cmd_word = 32'h0000_0002;
        tick(100);
        chk("notog_busy_rises", busy_rises, r0);
        chk("notog_pulses", en_pulses, p0);

        // Double flip during EXEC cancels
        p0 = en_pulses;
        cmd_word = 32'h8000_0141;
        wait_busy(1'b1, 5, "dbl_accept");
        tick(TS + TE + TH + 2);
        cmd_word = 32'h0000_0055;
        tick(10);
        cmd_word = 32'h8000_0066;
        wait_busy(1'b0, 200, "dbl_done");
        tick(50);
        chk("dbl_pulses", en_pulses, p0 + 1);
        chk("dbl_idle", {31'd0, busy}, 32'h0);

        // Triple flip during EXEC: one more transaction with the last word
        p0 = en_pulses;
        cmd_word = 32'h0000_0130;
        wait_busy(1'b1, 5, "tri_accept");
        tick(TS + TE + TH + 2);
        cmd_word = 32'h8000_0031;
        tick(10);
        cmd_word = 32'h0000_0032;
        tick(10);
        cmd_word = 32'h8000_0033;
        wait_busy(1'b0, 200, "tri_first_done");
        wait_busy(1'b1, 5, "tri_second_accept");
        chk("tri_data", {24'd0, lcd_data}, 32'h33);
        chk("tri_rs", {31'd0, lcd_rs}, 32'h0);
        wait_busy(1'b0, 200, "tri_second_done");
        tick(50);
        chk("tri_pulses", en_pulses, p0 + 2);

        // Async reset in the middle of ENH
        cmd_word = 32'h0000_0148;
        wait_en(20, "rst_en_rise");
        tick(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick(3);
        @(negedge clk);
        reset_n = 1'b1;
`ifdef LCD_PIO_SEQ_INIT_EN
        wait_busy(1'b0, 1500, "reinit_done");
        chk("reinit_last", {24'd0, lcd_data}, 32'h06);
`else
        r0 = busy_rises;
        tick(100);
        chk("postrst_no_txn", busy_rises, r0);
`endif
        p0 = en_pulses;
        cmd_word = 32'h8000_0149;
        wait_busy(1'b1, 5, "postrst_accept");
        wait_busy(1'b0, 200, "postrst_done");
        chk("postrst_data", {24'd0, lcd_data}, 32'h49);
        chk("postrst_rs", {31'd0, lcd_rs}, 32'h1);
        chk("postrst_pulses", en_pulses, p0 + 1);

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
